// File: rtl/force_pkt_tx_buffer.sv
// force_pkt_tx_buffer: egress FIFO between the cell-to-destination mapper and the ring router.
//
// Buffers force packets in a first-word-fall-through FIFO. Packets addressed to the local
// cell (HOME_CELL_ID) are discarded with a one-cycle self_drop pulse. A small FSM tracks
// the iteration: IDLE -> ACTIVE on the first accept, -> DRAIN once the last writeback is
// accepted, -> DONE when the FIFO has fully emptied, -> IDLE after one idle input cycle.
//
// Parameters:
//   HOME_CELL_ID  node ID of the local cell (self-address detection)
//   DEPTH         FIFO entries, power of 2, >= 2
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   pkt_in         packet from the mapper; pkt_in_valid / pkt_in_ready handshake
//   last_wb        marks pkt_in as the final writeback of the iteration
//   pkt_out        head packet to the router; pkt_out_valid / pkt_out_ready handshake
//   occupancy      number of stored entries (0..DEPTH)
//   self_drop      one-cycle pulse after a self-addressed packet is discarded
//   tx_done        high while in DONE
//   sent_count     (FORCE_PKT_TX_STATS_EN only) saturating count of transfers
//   drop_count     (FORCE_PKT_TX_STATS_EN only) saturating count of self drops
//
// Build option: define FORCE_PKT_TX_STATS_EN to add the sent_count/drop_count outputs.

package force_pkt_pkg;
    typedef struct packed {
        logic [7:0]  dest_id;
        logic [15:0] particle_id;
        logic [31:0] force_val;
    } packet_t;
endpackage

module force_pkt_tx_buffer
    import force_pkt_pkg::*;
#(
    parameter int unsigned HOME_CELL_ID = 0,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  packet_t                pkt_in,
    input  logic                   pkt_in_valid,
    output logic                   pkt_in_ready,
    input  logic                   last_wb,
    output packet_t                pkt_out,
    output logic                   pkt_out_valid,
    input  logic                   pkt_out_ready,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   self_drop,
    output logic                   tx_done
`ifdef FORCE_PKT_TX_STATS_EN
    ,
    output logic [31:0]            sent_count,
    output logic [15:0]            drop_count
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;
    localparam logic [7:0]  HomeId = 8'(HOME_CELL_ID);

    typedef enum logic [1:0] {StIdle, StActive, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]   occ_q, occ_d;
    logic              valid_q;
    logic              init_q;   // holds pkt_in_ready low until the first edge after reset
    logic              drop_q;
    packet_t           mem [DEPTH];

    logic full, accept, is_self, store, drop, xfer;

    always_comb begin
        full         = (occ_q == OccW'(DEPTH));
        pkt_in_ready = init_q && !full && (state_q != StDone);
        accept       = pkt_in_valid && pkt_in_ready;
        is_self      = (pkt_in.dest_id == HomeId);
        store        = accept && !is_self;
        drop         = accept && is_self;
        xfer         = valid_q && pkt_out_ready;
        occ_d        = occ_q + OccW'(store) - OccW'(xfer);
    end

    // Next-state logic and FSM outputs.
    always_comb begin
        state_d = state_q;
        tx_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = last_wb ? StDrain : StActive;
            end
            StActive: begin
                if (accept && last_wb) state_d = StDrain;
            end
            StDrain: begin
                // Done once nothing will remain stored after this edge; covers a dropped
                // last packet or an already-empty FIFO.
                if (occ_d == '0) state_d = StDone;
            end
            StDone: begin
                tx_done = 1'b1;
                if (!pkt_in_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            valid_q  <= 1'b0;
            init_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + PtrW'(store);
            rd_ptr_q <= rd_ptr_q + PtrW'(xfer);
            occ_q    <= occ_d;
            valid_q  <= (occ_d != '0);
            init_q   <= 1'b1;
            drop_q   <= drop;
        end
    end

    // Storage needs no reset: nothing is visible unless valid_q is set.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr_q] <= pkt_in;
    end

    // Head entry is held in registers, so pkt_out is stable while stalled.
    assign pkt_out       = valid_q ? mem[rd_ptr_q] : '0;
    assign pkt_out_valid = valid_q;
    assign occupancy     = occ_q;
    assign self_drop     = drop_q;

`ifdef FORCE_PKT_TX_STATS_EN
    logic [31:0] sent_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (xfer && (sent_q != '1))     sent_q     <= sent_q + 32'd1;
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign sent_count = sent_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_force_pkt_tx_buffer.sv
// Self-checking bench for force_pkt_tx_buffer (DEPTH=8, HOME_CELL_ID=4).
// Accepted non-self packets are queued as expected output and compared at each transfer.
module tb_force_pkt_tx_buffer;
    import force_pkt_pkg::*;

    localparam int unsigned Depth = 8;
    localparam logic [7:0]  Home  = 8'd4;

    logic                   clk = 1'b0;
    logic                   rst;
    packet_t                pkt_in;
    logic                   pkt_in_valid;
    logic                   pkt_in_ready;
    logic                   last_wb;
    packet_t                pkt_out;
    logic                   pkt_out_valid;
    logic                   pkt_out_ready;
    logic [$clog2(Depth):0] occupancy;
    logic                   self_drop;
    logic                   tx_done;
`ifdef FORCE_PKT_TX_STATS_EN
    logic [31:0]            sent_count;
    logic [15:0]            drop_count;
`endif

    force_pkt_tx_buffer #(
        .HOME_CELL_ID (4),
        .DEPTH        (Depth)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_in        (pkt_in),
        .pkt_in_valid  (pkt_in_valid),
        .pkt_in_ready  (pkt_in_ready),
        .last_wb       (last_wb),
        .pkt_out       (pkt_out),
        .pkt_out_valid (pkt_out_valid),
        .pkt_out_ready (pkt_out_ready),
        .occupancy     (occupancy),
        .self_drop     (self_drop),
        .tx_done       (tx_done)
`ifdef FORCE_PKT_TX_STATS_EN
        ,
        .sent_count    (sent_count),
        .drop_count    (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    packet_t exp_q[$];
    int      cyc = 0;
    int      last_xfer_edge = -1;
    int      sent_seen = 0;
    int      drop_seen = 0;
    int      occ_max = 0;
    int      seq = 0;
    logic    toggle_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Score the handshakes about to happen, advance one edge, then sample.
    task automatic tick();
        packet_t exp_pkt;
        if (pkt_out_valid && pkt_out_ready) begin
            last_xfer_edge = cyc + 1;
            sent_seen++;
            if (exp_q.size() == 0) begin
                check_eq("out_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_pkt = exp_q.pop_front();
                check_eq("out_pkt", 64'(pkt_out), 64'(exp_pkt));
            end
        end
        if (pkt_in_valid && pkt_in_ready && (pkt_in.dest_id != Home)) exp_q.push_back(pkt_in);
        @(posedge clk);
        #1;
        cyc++;
        if (self_drop) drop_seen++;
        if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
        if (toggle_en) pkt_out_ready = !pkt_out_ready;
    endtask

    task automatic send(input logic [7:0] dest, input logic last);
        int n;
        pkt_in.dest_id     = dest;
        pkt_in.particle_id = 16'(seq);
        pkt_in.force_val   = $urandom;
        seq++;
        last_wb      = last;
        pkt_in_valid = 1'b1;
        n = 0;
        while (!pkt_in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("send_ready", 64'(pkt_in_ready), 64'd1);
        tick();
        pkt_in_valid = 1'b0;
        last_wb      = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (pkt_out_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("drain_occ", 64'(occupancy), 64'd0);
        check_eq("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst           = 1'b1;
        pkt_in        = '0;
        pkt_in_valid  = 1'b0;
        last_wb       = 1'b0;
        pkt_out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(pkt_in_ready), 64'd0);
        check_eq("rst_valid", 64'(pkt_out_valid), 64'd0);
        check_eq("rst_occ", 64'(occupancy), 64'd0);
        check_eq("rst_drop", 64'(self_drop), 64'd0);
        check_eq("rst_done", 64'(tx_done), 64'd0);
        check_eq("rst_pkt", 64'(pkt_out), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        check_eq("ready_after_rst", 64'(pkt_in_ready), 64'd1);

        // Basic path: 1-cycle latency, occupancy never above 1
        pkt_out_ready = 1'b1;
        occ_max = 0;
        for (int i = 5; i <= 7; i++) begin
            send(8'(i), 1'b0);
            check_eq("basic_valid", 64'(pkt_out_valid), 64'd1);
            check_eq("basic_dest", 64'(pkt_out.dest_id), 64'(i));
        end
        drain();
        check_eq("basic_occ_max", 64'(occ_max), 64'd1);

        // Fill and backpressure
        pkt_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(10 + i), 1'b0);
        check_eq("fill_occ", 64'(occupancy), 64'd8);
        check_eq("fill_ready", 64'(pkt_in_ready), 64'd0);
        pkt_in.dest_id     = 8'd20;
        pkt_in.particle_id = 16'(seq);
        pkt_in.force_val   = $urandom;
        seq++;
        pkt_in_valid = 1'b1;
        tick();
        tick();
        check_eq("hold_occ", 64'(occupancy), 64'd8);
        check_eq("hold_ready", 64'(pkt_in_ready), 64'd0);
        check_eq("hold_head", 64'(pkt_out.dest_id), 64'd10);
        check_eq("hold_valid", 64'(pkt_out_valid), 64'd1);
        pkt_out_ready = 1'b1;
        tick();
        check_eq("unfull_ready", 64'(pkt_in_ready), 64'd1);
        check_eq("unfull_occ", 64'(occupancy), 64'd7);
        tick();
        pkt_in_valid = 1'b0;
        check_eq("ninth_occ", 64'(occupancy), 64'd7);
        drain();

        // Self-drop
        base = sent_seen;
        drop_seen = 0;
        send(8'd4, 1'b0);
        check_eq("drop_pulse", 64'(self_drop), 64'd1);
        send(8'd9, 1'b0);
        check_eq("drop_pulse_end", 64'(self_drop), 64'd0);
        send(8'd4, 1'b0);
        drain();
        check_eq("drop_pulses", 64'(drop_seen), 64'd2);
        check_eq("drop_sent", 64'(sent_seen - base), 64'd1);
`ifdef FORCE_PKT_TX_STATS_EN
        check_eq("drop_count", 64'(drop_count), 64'd2);
`endif

        // Drain to DONE with toggling router ready
        base = sent_seen;
        pkt_out_ready = 1'b1;
        toggle_en = 1'b1;
        for (int i = 0; i < 5; i++) send(8'(30 + i), (i == 4));
        n = 0;
        while (!tx_done && n < 60) begin
            tick();
            n++;
        end
        check_eq("tx_done_rise", 64'(tx_done), 64'd1);
        check_eq("tx_done_cycle", 64'(cyc), 64'(last_xfer_edge));
        check_eq("done_sent", 64'(sent_seen - base), 64'd5);
        check_eq("done_ready", 64'(pkt_in_ready), 64'd0);
        toggle_en = 1'b0;
        pkt_out_ready = 1'b1;
        tick();
        check_eq("done_fall", 64'(tx_done), 64'd0);
        check_eq("idle_ready", 64'(pkt_in_ready), 64'd1);

        // Asynchronous reset mid-stream
        pkt_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(40 + i), 1'b0);
        check_eq("pre_rst_occ", 64'(occupancy), 64'd5);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_occ", 64'(occupancy), 64'd0);
        check_eq("arst_valid", 64'(pkt_out_valid), 64'd0);
        check_eq("arst_pkt", 64'(pkt_out), 64'd0);
        check_eq("arst_ready", 64'(pkt_in_ready), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        check_eq("post_rst_occ", 64'(occupancy), 64'd0);
        check_eq("post_rst_valid", 64'(pkt_out_valid), 64'd0);
        check_eq("post_rst_ready", 64'(pkt_in_ready), 64'd1);
        check_eq("post_rst_done", 64'(tx_done), 64'd0);
        pkt_out_ready = 1'b1;
        send(8'd50, 1'b0);
        drain();

        // Pointer wrap with occupancy held at 1
        for (int i = 0; i < 20; i++) begin
            send(8'(60 + i), 1'b0);
            check_eq("wrap_occ", 64'(occupancy), 64'd1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
